dino_motion_ctrl: RTL and testbench
===================================

Name: dino_motion_ctrl

Overview:
- Parametrised vertical/horizontal motion controller for one sprite (the dinosaur) in the VGA game.
- Replaces the hard-coded fixed-step jump table with a velocity/gravity integrator, plus a duck state, fast-fall and clamped horizontal movement.
- Advances once per frame-rate `tick` strobe.
- Its `pos_x`/`pos_y` outputs feed the sprite address/compare logic in the top level; request inputs come from the edge-detected keypad decoder.

Parameters:
- X_W, 10: width of pos_x.
- Y_W, 9: width of pos_y.
- X_INIT, 320: pos_x reset value.
- X_MIN, 0: lowest legal pos_x.
- X_MAX, 512: highest legal pos_x (640 minus sprite width 128).
- X_STEP, 20: pixels moved per left/right request.
- GROUND_Y, 240: resting pos_y; also the reset value.
- Y_MIN, 0: ceiling; pos_y never goes below it.
- V0, 16: launch velocity in px/tick, upward-positive.
- GRAV, 1: velocity decrement per tick.
- V_MAX, 16: terminal fall speed (velocity floor is -V_MAX).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- tick, in, 1: one-cycle frame strobe that advances physics.
- jump_req, in, 1: one-cycle jump request pulse.
- duck, in, 1: level input, duck / fast-fall.
- left_req, in, 1: one-cycle pulse, move left.
- right_req, in, 1: one-cycle pulse, move right.
- pos_x, out, X_W: sprite left column.
- pos_y, out, Y_W: sprite top row.
- state, out, 2: 0 GROUND, 1 RISE, 2 FALL, 3 DUCK.
- airborne, out, 1: high when state is RISE or FALL.
- landed, out, 1: one-cycle pulse on touchdown.

Behaviour:
- Reset values: pos_x=X_INIT, pos_y=GROUND_Y, state=GROUND, airborne=0, landed=0, internal velocity v=0, jump-pending flag cleared. Reset mid-jump aborts immediately to these values.
- Internal v is signed, Y_W+2 bits. Position arithmetic is done in signed Y_W+2 bits, then clamped before truncation.
- jump pending flag:
  - Set by jump_req on any cycle.
  - Consumed and cleared on every tick.
  - jump_req coincident with tick counts for that tick.
- Horizontal movement (independent of tick, applied the cycle after the request):
  - left: pos_x = max(pos_x - X_STEP, X_MIN).
  - right: pos_x = min(pos_x + X_STEP, X_MAX).
  - left and right in the same cycle: no move.
  - Allowed in every state.
- On tick, by state:
  - GROUND: pending jump → v=V0, state=RISE, pos_y unchanged (launch tick). Else if duck=1 → DUCK. Else stay.
  - DUCK: duck=0 → GROUND. Jump requests are ignored and discarded.
  - RISE/FALL:
    - y_next = pos_y - v.
    - dec = 2·GRAV if duck=1 (fast-fall), else GRAV.
    - v_next = max(v - dec, -V_MAX).
    - If y_next ≥ GROUND_Y: pos_y=GROUND_Y, v=0, state=GROUND, landed=1 for exactly that cycle.
    - Else if y_next < Y_MIN: pos_y=Y_MIN, v=0, state=FALL.
    - Otherwise: pos_y=y_next, v=v_next, state = RISE if v_next>0, else FALL.
- Between ticks, pos_y and state hold. landed is 0 on all cycles except the touchdown cycle.
- airborne is a registered decode of the next state; it has the same timing as state.

Optional Feature:
- Macro: DINO_DOUBLE_JUMP_EN.
- With the macro defined:
  - A pending jump on a tick while RISE/FALL is accepted once per flight: v=V0, state=RISE, pos_y unchanged.
  - The one-per-flight flag clears on landing or reset.
- Without the macro, airborne jump requests are discarded. The flag logic is absent.

Test Plan:
1. Full jump trajectory. Params V0=4, GRAV=1, GROUND_Y=240; jump_req, then ticks T0..T9. Required pos_y after each tick: 240(RISE), 236, 233, 231, 230(FALL), 230, 231, 233, 236, then 240 with landed=1 for one cycle and state=GROUND.
2. Move right then left. rst, then 10 right_req pulses: pos_x goes 320→340→…, saturating at 512. Then 30 left_req pulses: pos_x saturates at 0. Simultaneous left+right: pos_x unchanged.
3. Duck. duck=1 and tick on GROUND → state=3. Then jump_req+tick → state stays 3, pos_y=240. Then duck=0+tick → state=0. With duck=1 mid-flight (V0=4), the descent reaches ground in fewer ticks than scenario 1 (touchdown by T8).
4. Reset and pulse timing.
   - rst asserted at T3 of scenario 1 → next cycle pos_y=240, state=0, v=0, landed=0.
   - jump_req and tick in the same cycle → launch on that tick.
   - jump_req 5 cycles before a tick → launch on that tick. A second tick with no new request → no relaunch.
5. Ceiling clamp. Y_MIN=230, GROUND_Y=240, V0=16: first motion tick clamps pos_y to 230, state=FALL, v=0.
6. Double jump. With DINO_DOUBLE_JUMP_EN, jump_req at T2 of scenario 1 → v reloads to 4, state=RISE; a third jump_req while airborne is ignored. Without the macro, the same stimulus reproduces scenario 1 exactly.

Source files
------------

// File: rtl/dino_motion_if.sv
`default_nettype none
// ============================================================================
// Module      : dino_motion_if
// Description : Keypad-request / sprite-position bundle of the dino motion
//               controller. The keypad side is master, the controller is slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface dino_motion_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           tick;
    logic           jump_req;
    logic           duck;
    logic           left_req;
    logic           right_req;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic [1:0]     state;
    logic           airborne;
    logic           landed;

    modport master (
        output tick, jump_req, duck, left_req, right_req,
        input  pos_x, pos_y, state, airborne, landed
    );

    modport slave (
        input  tick, jump_req, duck, left_req, right_req,
        output pos_x, pos_y, state, airborne, landed
    );
endinterface
`default_nettype wire

// File: rtl/dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dino_motion_ctrl
// Description : Per-tick velocity/gravity integrator for the dinosaur sprite,
//               with duck, fast-fall and clamped horizontal moves.
//               Define DINO_DOUBLE_JUMP_EN to allow one mid-air jump per flight.
// Revision    : 1.0 - initial release
// ============================================================================
module dino_motion_ctrl #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int X_INIT   = 320,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 512,
    parameter int X_STEP   = 20,
    parameter int GROUND_Y = 240,
    parameter int Y_MIN    = 0,
    parameter int V0       = 16,
    parameter int GRAV     = 1,
    parameter int V_MAX    = 16
) (
    input  logic          clk,
    input  logic          rst,
    dino_motion_if.slave  bus
);
    localparam int VW  = Y_W + 2;
    localparam int XW2 = X_W + 2;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2,
        ST_DUCK   = 2'd3
    } state_t;

    localparam logic signed [VW-1:0] c_v0       = VW'(V0);
    localparam logic signed [VW-1:0] c_grav     = VW'(GRAV);
    localparam logic signed [VW-1:0] c_grav2    = VW'(2 * GRAV);
    localparam logic signed [VW-1:0] c_vmin     = VW'(-V_MAX);
    localparam logic signed [VW-1:0] c_ground   = VW'(GROUND_Y);
    localparam logic signed [VW-1:0] c_ymin     = VW'(Y_MIN);
    localparam logic [Y_W-1:0]       c_ground_y = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0]       c_ymin_y   = Y_W'(Y_MIN);
    localparam logic [X_W-1:0]       c_x_init   = X_W'(X_INIT);
    localparam logic [XW2-1:0]       c_x_min    = XW2'(X_MIN);
    localparam logic [XW2-1:0]       c_x_max    = XW2'(X_MAX);
    localparam logic [XW2-1:0]       c_x_step   = XW2'(X_STEP);

    state_t                r_state, w_state;
    logic [X_W-1:0]        r_pos_x, w_pos_x;
    logic [Y_W-1:0]        r_pos_y, w_pos_y;
    logic signed [VW-1:0]  r_v, w_v;
    logic signed [VW-1:0]  w_y_next, w_v_dec, w_v_next;
    logic [XW2-1:0]        w_x_ext;
    logic                  r_jump_pend, w_jump_pend, w_jump;
    logic                  r_landed, w_landed;
    logic                  r_airborne, w_airborne;
    logic                  w_relaunch;

    // Second jump is allowed only while the per-flight flag is still clear.
`ifdef DINO_DOUBLE_JUMP_EN
    logic r_dj_used;

    assign w_relaunch = w_jump & ~r_dj_used;

    always_ff @(posedge clk) begin
        if (rst || w_landed) begin
            r_dj_used <= 1'b0;
        end else if (bus.tick && w_relaunch &&
                     (r_state == ST_RISE || r_state == ST_FALL)) begin
            r_dj_used <= 1'b1;
        end
    end
`else
    assign w_relaunch = 1'b0;
`endif

    assign w_jump   = r_jump_pend | bus.jump_req;
    assign w_y_next = $signed({2'b00, r_pos_y}) - r_v;
    assign w_v_dec  = r_v - (bus.duck ? c_grav2 : c_grav);
    assign w_v_next = (w_v_dec < c_vmin) ? c_vmin : w_v_dec;
    assign w_x_ext  = XW2'(r_pos_x);

    always_comb begin
        w_pos_x = r_pos_x;
        if (bus.left_req && !bus.right_req) begin
            w_pos_x = (w_x_ext < c_x_min + c_x_step) ? X_W'(c_x_min)
                                                     : X_W'(w_x_ext - c_x_step);
        end else if (bus.right_req && !bus.left_req) begin
            w_pos_x = (w_x_ext + c_x_step > c_x_max) ? X_W'(c_x_max)
                                                     : X_W'(w_x_ext + c_x_step);
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pos_y     = r_pos_y;
        w_v         = r_v;
        w_landed    = 1'b0;
        w_jump_pend = bus.tick ? 1'b0 : w_jump;
        if (bus.tick) begin
            case (r_state)
                ST_GROUND: begin
                    if (w_jump) begin
                        w_v     = c_v0;
                        w_state = ST_RISE;
                    end else if (bus.duck) begin
                        w_state = ST_DUCK;
                    end
                end
                ST_DUCK: begin
                    if (!bus.duck) w_state = ST_GROUND;
                end
                ST_RISE, ST_FALL: begin
                    if (w_relaunch) begin
                        w_v     = c_v0;
                        w_state = ST_RISE;
                    end else if (w_y_next >= c_ground) begin
                        w_pos_y  = c_ground_y;
                        w_v      = '0;
                        w_state  = ST_GROUND;
                        w_landed = 1'b1;
                    end else if (w_y_next < c_ymin) begin
                        w_pos_y = c_ymin_y;
                        w_v     = '0;
                        w_state = ST_FALL;
                    end else begin
                        w_pos_y = Y_W'(w_y_next);
                        w_v     = w_v_next;
                        w_state = (w_v_next > 0) ? ST_RISE : ST_FALL;
                    end
                end
                default: ;
            endcase
        end
        w_airborne = (w_state == ST_RISE) || (w_state == ST_FALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_GROUND;
            r_pos_x     <= c_x_init;
            r_pos_y     <= c_ground_y;
            r_v         <= '0;
            r_jump_pend <= 1'b0;
            r_landed    <= 1'b0;
            r_airborne  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pos_x     <= w_pos_x;
            r_pos_y     <= w_pos_y;
            r_v         <= w_v;
            r_jump_pend <= w_jump_pend;
            r_landed    <= w_landed;
            r_airborne  <= w_airborne;
        end
    end

    assign bus.pos_x    = r_pos_x;
    assign bus.pos_y    = r_pos_y;
    assign bus.state    = r_state;
    assign bus.airborne = r_airborne;
    assign bus.landed   = r_landed;
endmodule
`default_nettype wire

// File: tb/tb_dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dino_motion_ctrl
// Description : Scoreboard bench for dino_motion_ctrl (V0=4 instance plus a
//               ceiling-clamp instance with Y_MIN=230, V0=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_motion_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    dino_motion_if #(.X_W(10), .Y_W(9)) aif ();
    dino_motion_if #(.X_W(10), .Y_W(9)) bif ();

    assign bif.tick      = aif.tick;
    assign bif.jump_req  = aif.jump_req;
    assign bif.duck      = aif.duck;
    assign bif.left_req  = aif.left_req;
    assign bif.right_req = aif.right_req;

    dino_motion_ctrl #(
        .X_W(10), .Y_W(9), .X_INIT(320), .X_MIN(0), .X_MAX(512), .X_STEP(20),
        .GROUND_Y(240), .Y_MIN(0), .V0(4), .GRAV(1), .V_MAX(16)
    ) dut_a (.clk(clk), .rst(rst), .bus(aif.slave));

    dino_motion_ctrl #(
        .X_W(10), .Y_W(9), .X_INIT(320), .X_MIN(0), .X_MAX(512), .X_STEP(20),
        .GROUND_Y(240), .Y_MIN(230), .V0(16), .GRAV(1), .V_MAX(16)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(bif.slave));

    typedef struct {
        string      name;
        int         due;
        int         dut;
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] st;
        logic       land;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc_n   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ex_x    = 320;
    bit   duck_lvl  = 1'b0;
    bit   rst_lvl   = 1'b1;
    bit   rst_b_lvl = 1'b1;

    int s1_y [10] = '{240, 236, 233, 231, 230, 230, 231, 233, 236, 240};
    int s1_st[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 0};
    int ff_y [5]  = '{236, 234, 234, 236, 240};
    int ff_st[5]  = '{1, 2, 2, 2, 0};
`ifdef DINO_DOUBLE_JUMP_EN
    localparam int DJ_N = 13;
    int dj_y [13] = '{240, 236, 236, 232, 229, 227, 226, 226, 227, 229, 232, 236, 240};
    int dj_st[13] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 0};
`else
    localparam int DJ_N = 10;
    int dj_y [13] = '{240, 236, 233, 231, 230, 230, 231, 233, 236, 240, 0, 0, 0};
    int dj_st[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 0, 0, 0, 0};
`endif

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: every entry becomes due one edge after the stimulus that produced it.
    initial begin
        forever begin
            logic [9:0] gx;
            logic [8:0] gy;
            logic [1:0] gst;
            logic       gair, gland, wair;
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc_n) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    gx = aif.pos_x; gy = aif.pos_y; gst = aif.state;
                    gair = aif.airborne; gland = aif.landed;
                end else begin
                    gx = bif.pos_x; gy = bif.pos_y; gst = bif.state;
                    gair = bif.airborne; gland = bif.landed;
                end
                wair = (e.st == 2'd1) || (e.st == 2'd2);
                n_tests++;
                if ({gx, gy, gst, gair, gland} !== {e.x, e.y, e.st, wair, e.land}) begin
                    n_fail++;
                    $display("FAIL %s (dut%0d): got x=%0d y=%0d st=%0d air=%0d landed=%0d, want x=%0d y=%0d st=%0d air=%0d landed=%0d",
                             e.name, e.dut, gx, gy, gst, gair, gland,
                             e.x, e.y, e.st, wair, e.land);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic step(input bit t, input bit j, input bit l, input bit r);
        @(negedge clk);
        rst           = rst_lvl;
        rst_b         = rst_b_lvl;
        aif.tick      = t;
        aif.jump_req  = j;
        aif.left_req  = l;
        aif.right_req = r;
        aif.duck      = duck_lvl;
    endtask

    task automatic want(input string nm, input int d, input int x, input int y,
                        input int st, input bit land);
        exp_t w;
        w.name = nm;
        w.due  = cyc_n + 1;
        w.dut  = d;
        w.x    = 10'(x);
        w.y    = 9'(y);
        w.st   = 2'(st);
        w.land = land;
        q.push_back(w);
    endtask

    task automatic tick_chk(input string nm, input bit j, input int y, input int st,
                            input bit land);
        step(1'b1, j, 1'b0, 1'b0);
        want(nm, 0, ex_x, y, st, land);
    endtask

    task automatic idle_chk(input string nm, input int y, input int st);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        want(nm, 0, ex_x, y, st, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        want("reset_a", 0, 320, 240, 0, 1'b0);
        want("reset_b", 1, 320, 240, 0, 1'b0);
        rst_lvl = 1'b0;

        // Full trajectory, with a hold check between ticks
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s1_req", 0, ex_x, 240, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick_chk("s1_tick", 1'b0, s1_y[i], s1_st[i], i == 9);
            idle_chk("s1_hold", s1_y[i], s1_st[i]);
        end

        // Horizontal saturation
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            ex_x = (ex_x + 20 > 512) ? 512 : ex_x + 20;
            want("s2_right", 0, ex_x, 240, 0, 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            ex_x = (ex_x < 20) ? 0 : ex_x - 20;
            want("s2_left", 0, ex_x, 240, 0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ex_x = 20;
        want("s2_right_from_0", 0, ex_x, 240, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        want("s2_both", 0, ex_x, 240, 0, 1'b0);

        // Duck, jump discarded in duck, then fast-fall flight
        duck_lvl = 1'b1;
        tick_chk("s3_duck", 1'b0, 240, 3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s3_duck_req", 0, ex_x, 240, 3, 1'b0);
        tick_chk("s3_duck_jump", 1'b0, 240, 3, 1'b0);
        duck_lvl = 1'b0;
        tick_chk("s3_unduck", 1'b0, 240, 0, 1'b0);
        tick_chk("s3_no_stale", 1'b0, 240, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s3_ff_req", 0, ex_x, 240, 0, 1'b0);
        tick_chk("s3_ff_launch", 1'b0, 240, 1, 1'b0);
        duck_lvl = 1'b1;
        for (int i = 0; i < 5; i++) tick_chk("s3_ff_tick", 1'b0, ff_y[i], ff_st[i], i == 4);
        duck_lvl = 1'b0;
        idle_chk("s3_ff_after", 240, 0);

        // Reset mid-flight (with a coincident jump that must be dropped)
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s4_req", 0, ex_x, 240, 0, 1'b0);
        for (int i = 0; i < 3; i++) tick_chk("s4_tick", 1'b0, s1_y[i], s1_st[i], 1'b0);
        rst_lvl = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        ex_x = 320;
        want("s4_rst", 0, ex_x, 240, 0, 1'b0);
        rst_lvl = 1'b0;
        tick_chk("s4_after_rst", 1'b0, 240, 0, 1'b0);
        tick_chk("s4_coinc", 1'b1, 240, 1, 1'b0);
        for (int i = 1; i < 10; i++) tick_chk("s4_coinc_fly", 1'b0, s1_y[i], s1_st[i], i == 9);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s4_early_req", 0, ex_x, 240, 0, 1'b0);
        for (int i = 0; i < 4; i++) idle_chk("s4_early_wait", 240, 0);
        tick_chk("s4_early_launch", 1'b0, 240, 1, 1'b0);
        tick_chk("s4_no_relaunch", 1'b0, 236, 1, 1'b0);
        for (int i = 2; i < 10; i++) tick_chk("s4_early_fly", 1'b0, s1_y[i], s1_st[i], i == 9);
        tick_chk("s4_stay_ground", 1'b0, 240, 0, 1'b0);

        // Airborne jump requests at T2 and T4
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s6_req", 0, ex_x, 240, 0, 1'b0);
        for (int i = 0; i < DJ_N; i++)
            tick_chk("s6_tick", (i == 2) || (i == 4), dj_y[i], dj_st[i], i == DJ_N - 1);

        // Ceiling clamp on the second instance
        rst_b_lvl = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        want("s5_req", 1, 320, 240, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        want("s5_launch", 1, 320, 240, 1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        want("s5_clamp", 1, 320, 230, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        want("s5_v_zero", 1, 320, 230, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        want("s5_descend", 1, 320, 231, 2, 1'b0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
